// File: rtl/mulf_arbiter.sv
// ============================================================================
// Module   : mulf_arbiter (with internal datapath mulf)
// Purpose  : Round-robin share of one single-precision multiplier between
//            NREQ requesters; one operation in flight, tagged valid/ready
//            response after LAT settle cycles.
// Options  : MULF_ARB_ZERO_EN - zero/denormal operand forces a signed zero.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

// Truncating float multiply: no rounding, no special-value handling,
// exponent wraps modulo 256.
module mulf (
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic [31:0] s
);
   logic [23:0] ma;
   logic [23:0] mb;
   logic [47:0] prod;
   logic [7:0]  exp_sum;
   logic [22:0] mant;

   assign ma      = {1'b1, a[22:0]};
   assign mb      = {1'b1, b[22:0]};
   assign prod    = {24'b0, ma} * {24'b0, mb};
   // Product of two 1.x mantissas lies in [1,4); bit 47 means renormalise.
   assign exp_sum = a[30:23] + b[30:23] - 8'd127 + {7'b0, prod[47]};
   assign mant    = prod[47] ? prod[46:24] : prod[45:23];
   assign s       = {a[31] ^ b[31], exp_sum, mant};
endmodule

module mulf_arbiter #(
   parameter int NREQ = 4,
   parameter int LAT  = 2,
   parameter int IDW  = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NREQ-1:0]   req_valid,
   output logic [NREQ-1:0]   req_ready,
   input  logic [32*NREQ-1:0] req_a,
   input  logic [32*NREQ-1:0] req_b,
   output logic              resp_valid,
   input  logic              resp_ready,
   output logic [IDW-1:0]    resp_id,
   output logic [31:0]       resp_s,
   output logic              busy
);
   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_EXEC = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;
   localparam int         CNT_W  = 4;

   logic [1:0]       r_state;
   logic [1:0]       w_next;
   logic [31:0]      r_op_a;
   logic [31:0]      r_op_b;
   logic [CNT_W-1:0] r_cnt;
   logic [IDW-1:0]   r_ptr;
   logic [IDW-1:0]   r_resp_id;
   logic [31:0]      r_resp_s;

   logic             w_found;
   logic [IDW-1:0]   w_gnt_idx;
   logic [NREQ-1:0]  w_gnt_oh;
   logic [31:0]      w_sel_a;
   logic [31:0]      w_sel_b;
   logic [31:0]      w_mul_s;
   logic [31:0]      w_result;

   // Circular priority search starting one past the last grant.
   always_comb begin
      w_found   = 1'b0;
      w_gnt_idx = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (!w_found && req_valid[i] && (i > int'(r_ptr))) begin
            w_found   = 1'b1;
            w_gnt_idx = IDW'(i);
         end
      end
      for (int i = 0; i < NREQ; i++) begin
         if (!w_found && req_valid[i] && (i <= int'(r_ptr))) begin
            w_found   = 1'b1;
            w_gnt_idx = IDW'(i);
         end
      end
   end

   // Operand mux for the winning requester.
   always_comb begin
      w_sel_a  = '0;
      w_sel_b  = '0;
      w_gnt_oh = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (w_found && (i == int'(w_gnt_idx))) begin
            w_sel_a     = req_a[i*32 +: 32];
            w_sel_b     = req_b[i*32 +: 32];
            w_gnt_oh[i] = 1'b1;
         end
      end
   end

   mulf u_mulf (
      .a (r_op_a),
      .b (r_op_b),
      .s (w_mul_s)
   );

   // Result selection in front of the result register.
   always_comb begin
`ifdef MULF_ARB_ZERO_EN
      if ((r_op_a[30:23] == 8'd0) || (r_op_b[30:23] == 8'd0))
         w_result = {r_op_a[31] ^ r_op_b[31], 31'b0};
      else
         w_result = w_mul_s;
`else
      w_result = w_mul_s;
`endif
   end

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         r_state <= S_IDLE;
      else
         r_state <= w_next;
   end

   // Next-state logic.
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (w_found)           w_next = S_EXEC;
         S_EXEC:  if (r_cnt == '0)       w_next = S_DONE;
         S_DONE:  if (resp_ready)        w_next = S_IDLE;
         default:                        w_next = S_IDLE;
      endcase
   end

   // Output decode; the grant is only visible while idle.
   always_comb begin
      req_ready  = (r_state == S_IDLE) ? w_gnt_oh : '0;
      resp_valid = (r_state == S_DONE);
      busy       = (r_state != S_IDLE);
   end

   // Operand capture, settle counter, pointer and result registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_op_a    <= '0;
         r_op_b    <= '0;
         r_cnt     <= '0;
         r_ptr     <= IDW'(NREQ-1);
         r_resp_id <= '0;
         r_resp_s  <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_found) begin
                  r_op_a    <= w_sel_a;
                  r_op_b    <= w_sel_b;
                  r_cnt     <= CNT_W'(LAT-1);
                  r_ptr     <= w_gnt_idx;
                  r_resp_id <= w_gnt_idx;
               end
            end
            S_EXEC: begin
               if (r_cnt != '0)
                  r_cnt <= r_cnt - 1'b1;
               else
                  r_resp_s <= w_result;
            end
            default: ;
         endcase
      end
   end

   assign resp_id = r_resp_id;
   assign resp_s  = r_resp_s;

endmodule

`default_nettype wire

// File: doc/mulf_arbiter.md
Name: mulf_arbiter

Overview:
- Shares one single-precision float multiplier (existing `mulf` datapath, instantiated internally) between NREQ requesters.
- Selects requesters round-robin and registers the granted operands.
- Holds the operation for a programmable number of settle cycles, then returns the product with a requester tag on a valid/ready response port.
- Exactly one operation is in flight at a time; the block sits between the integer/float issue logic and the shared multiplier.

Parameters:
- NREQ, 4, number of requesters; legal range 2..8.
- LAT, 2, settle cycles between operand capture and result capture; legal range 1..15.
- IDW, 2, response tag width; must equal ceil(log2(NREQ)).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- req_valid  in  NREQ  bit i set: requester i has an operation pending.
- req_ready  out  NREQ  one-hot or zero; bit i set: requester i is accepted this cycle.
- req_a  in  32*NREQ  operand A of requester i, in bits [32i+31:32i].
- req_b  in  32*NREQ  operand B of requester i, same packing.
- resp_valid  out  1  result available.
- resp_ready  in  1  consumer accepts the result.
- resp_id  out  IDW  index of the requester that owns the result.
- resp_s  out  32  product, IEEE-754 single-precision bit pattern.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset values: state=IDLE, req_ready=0, resp_valid=0, resp_id=0, resp_s=0, busy=0, counter=0, last-grant pointer=NREQ-1 (requester 0 wins first).
- FSM has three states: IDLE, EXEC, DONE.
- IDLE:
  - req_ready is combinational: one-hot at the first set req_valid bit, searching circularly from pointer+1.
  - If any req_valid bit is set: the granted a/b are latched into operand registers, resp_id is loaded with the grant index, pointer takes the grant index, counter=LAT-1, and the FSM moves to EXEC.
  - The handshake completes in the same cycle (req_valid & req_ready).
- EXEC:
  - req_ready=0.
  - Operand registers drive the multiplier.
  - While counter>0, the counter decrements.
  - When counter==0, the multiplier output is registered into resp_s, resp_valid is set, and the FSM moves to DONE.
- DONE:
  - resp_valid=1. resp_s and resp_id are held stable until resp_ready=1.
  - On resp_ready=1: resp_valid is cleared and the FSM returns to IDLE.
  - A new grant is issued no earlier than the cycle after the response handshake; there is no bypass.
- Latency: request handshake cycle T gives resp_valid high at edge T+LAT+1.
- Throughput: at most one operation per LAT+2 cycles.
- Arbitration is fair: with all requesters valid continuously, the grant order is 0,1,2,…,NREQ-1,0,…
- req_valid deasserted by a requester while it is not granted is legal and has no effect.
- Operand inputs are sampled only on the grant cycle; later changes are ignored.
- resp_ready while resp_valid=0 is ignored.
- Reset asserted mid-operation: the operation is discarded immediately, all outputs return to reset values, and no response is produced.
- Arithmetic is exactly that of the shared multiplier:
  - sign = xor of the operand signs;
  - exponent = ea+eb-127, wrapping modulo 256;
  - product truncated, no rounding;
  - no overflow, NaN or Inf handling.

Optional Feature:
- Macro: MULF_ARB_ZERO_EN.
- Defined: a zero-detect stage sits in front of the result register. Any operand with exponent field 0 (zero or denormal) forces resp_s = {sa^sb, 31'b0}, replacing the multiplier output. Latency is unchanged.
- Undefined: resp_s is always the raw multiplier output; a zero operand yields an unspecified non-zero pattern.

Test Plan:
- Reset, then a single request on requester 2 with a=0x40000000, b=0x40400000 (LAT=2) -> req_ready=4'b0100 for one cycle; resp_valid rises 3 cycles later with resp_s=0x40C00000, resp_id=2.
- All four requesters valid continuously with resp_ready tied high; requester i sends a=0x40400000, b=0x40400000 -> grants in order 0,1,2,3,0; every response is 0x41100000 with resp_id matching the grant.
- resp_ready held low for 10 cycles after resp_valid -> resp_s and resp_id stay stable, busy=1, req_ready=0 throughout; the grant follows the cycle after resp_ready rises.
- rst pulsed asynchronously (mid-cycle) during EXEC -> resp_valid, busy and req_ready drop immediately; no response appears afterward; the next grant goes to requester 0.
- MULF_ARB_ZERO_EN defined, a=0x80000000, b=0x40400000 -> resp_s=0x80000000; with the macro undefined, the bench checks only that resp_valid and resp_id are correct.
- a=0x3F800000, b=0xBF800000 with LAT=1 -> resp_s=0xBF800000, resp_valid at T+2.
